// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter: NUM_REQ valid/ready producers share one FIFO
// write port. A winner holds the port for up to BURST_MAX beats. The winner
// releases the port early if it drops valid. Each release costs one idle
// cycle before the next grant.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic [15:0]                   write_count
);

    localparam int          ID_W      = $clog2(NUM_REQ);
    localparam int unsigned NREQ      = NUM_REQ;
    localparam logic [7:0]  LAST_BEAT = 8'(BURST_MAX - 1);
    localparam logic [ID_W-1:0] LAST_ID_RST = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t            state_q, state_d;
    logic              grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic [15:0]       write_count_q, write_count_d;

    logic              rr_found;
    logic [ID_W-1:0]   rr_winner;
    logic              owner_valid;
    logic              beat_accept;

    // Producer index reached by stepping 'step' places past 'base', wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] rr_slot(input logic [ID_W-1:0] base,
                                                input int unsigned     step);
        return ID_W'((32'(base) + step) % NREQ);
    endfunction

    // State register and registered outputs; reset makes producer 0 win first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            last_id_q     <= LAST_ID_RST;
            beat_cnt_q    <= '0;
            write_count_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            last_id_q     <= last_id_d;
            beat_cnt_q    <= beat_cnt_d;
            write_count_q <= write_count_d;
        end
    end

    // Round-robin search: first valid producer after the previous winner.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!rr_found && req_valid[rr_slot(last_id_q, k)]) begin
                rr_found  = 1'b1;
                rr_winner = rr_slot(last_id_q, k);
            end
        end
    end

    // Next-state logic: grant in IDLE, count beats and release the lock in BURST.
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_id_d     = last_id_q;
        beat_cnt_d    = beat_cnt_q;
        write_count_d = write_count_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d    = BURST;
                    grant_id_d = rr_winner;
                    last_id_d  = rr_winner;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                // A dropped valid releases the lock even while the FIFO is full.
                if (!owner_valid) begin
                    state_d = IDLE;
                end else if (beat_accept) begin
                    beat_cnt_d    = beat_cnt_q + 8'd1;
                    write_count_d = write_count_q + 16'd1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        grant_valid_d = (state_d == BURST);
    end

    // Output logic: owner's ready follows !fifo_full; write only on an accepted beat.
    always_comb begin
        req_ready    = '0;
        owner_valid  = 1'b0;
        beat_accept  = 1'b0;
        fifo_w_en    = 1'b0;
        fifo_data_in = '0;
        if (state_q == BURST) begin
            owner_valid           = req_valid[grant_id_q];
            req_ready[grant_id_q] = !fifo_full;
            beat_accept           = owner_valid && !fifo_full;
            if (beat_accept) begin
                fifo_w_en    = 1'b1;
                fifo_data_in = req_data[32'(grant_id_q) * DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign write_count = write_count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter. Three instances share clock and reset:
// BURST_MAX=4, BURST_MAX=1 and BURST_MAX=255.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [3:0]  a_valid, a_ready, b_valid, b_ready, c_valid, c_ready;
    logic [31:0] a_data, b_data, c_data;
    logic        a_full, b_full, c_full;
    logic        a_wen, b_wen, c_wen;
    logic [7:0]  a_din, b_din, c_din;
    logic        a_gv, b_gv, c_gv;
    logic [1:0]  a_gid, b_gid, c_gid;
    logic [15:0] a_wc, b_wc, c_wc;

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(4)) dA (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
        .fifo_full(a_full), .fifo_w_en(a_wen), .fifo_data_in(a_din),
        .grant_valid(a_gv), .grant_id(a_gid), .write_count(a_wc));

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(1)) dB (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
        .fifo_full(b_full), .fifo_w_en(b_wen), .fifo_data_in(b_din),
        .grant_valid(b_gv), .grant_id(b_gid), .write_count(b_wc));

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(255)) dC (
        .clk(clk), .rst(rst), .req_valid(c_valid), .req_data(c_data), .req_ready(c_ready),
        .fifo_full(c_full), .fifo_w_en(c_wen), .fifo_data_in(c_din),
        .grant_valid(c_gv), .grant_id(c_gid), .write_count(c_wc));

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [1:0] id_q[$];

    task automatic test_reset();
        a_valid = '0; b_valid = '0; c_valid = '0;
        a_data = '0; b_data = '0; c_data = '0;
        a_full = 1'b0; b_full = 1'b0; c_full = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (a_gv !== 1'b0) begin n_fail++; $display("FAIL reset_gv got=%0b exp=0", a_gv); end
        n_cmp++; if (a_gid !== 2'd0) begin n_fail++; $display("FAIL reset_gid got=%0d exp=0", a_gid); end
        n_cmp++; if (a_wc !== 16'd0) begin n_fail++; $display("FAIL reset_wc got=%0d exp=0", a_wc); end
        n_cmp++; if (a_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got=%0b exp=0", a_wen); end
        n_cmp++; if (a_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", a_ready); end
        n_cmp++; if (dA.last_id_q !== 2'd3) begin n_fail++; $display("FAIL reset_last_id got=%0d exp=3", dA.last_id_q); end
        n_cmp++; if (dA.beat_cnt_q !== 8'd0) begin n_fail++; $display("FAIL reset_beat_cnt got=%0d exp=0", dA.beat_cnt_q); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_stream();
        int sent = 0;
        int nw = 0;
        int wcyc[6];
        bit done = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(8'hA0 + 8'(i));
        a_valid = 4'b0100;
        a_data[23:16] = 8'hA0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            bit acc;
            logic [7:0] e;
            acc = 1'b0;
            @(negedge clk);
            if (a_gv) begin
                n_cmp++; if (a_gid !== 2'd2) begin n_fail++; $display("FAIL stream_gid got=%0d exp=2", a_gid); end
            end
            if (a_wen) begin
                acc = 1'b1;
                if (nw < 6) wcyc[nw] = cyc;
                nw++;
                n_cmp++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL stream_extra_write got=%02h exp=none", a_din); end
                else begin
                    e = exp_q.pop_front();
                    if (a_din !== e) begin n_fail++; $display("FAIL stream_data got=%02h exp=%02h", a_din, e); end
                end
            end
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent == 6) begin a_valid = '0; done = 1'b1; end
                else a_data[23:16] = 8'hA0 + 8'(sent);
            end
        end
        n_cmp++; if (!done) begin n_fail++; $display("FAIL stream_timeout got=%0d exp=6 beats", sent); end
        if (done) begin
            for (int i = 1; i < 6; i++) begin
                n_cmp++;
                if (wcyc[i] - wcyc[i-1] !== ((i == 4) ? 2 : 1)) begin
                    n_fail++; $display("FAIL stream_gap%0d got=%0d exp=%0d", i, wcyc[i] - wcyc[i-1], (i == 4) ? 2 : 1);
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_left got=%0d exp=0", exp_q.size()); end
        n_cmp++; if (a_wc !== 16'd6) begin n_fail++; $display("FAIL stream_wc got=%0d exp=6", a_wc); end
    endtask

    task automatic test_round_robin();
        logic [1:0] eid;
        id_q.delete();
        id_q.push_back(2'd0); id_q.push_back(2'd1); id_q.push_back(2'd2);
        id_q.push_back(2'd3); id_q.push_back(2'd0); id_q.push_back(2'd1);
        b_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        b_valid = 4'hF;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_cmp++; if (b_wen !== 1'(k % 2)) begin n_fail++; $display("FAIL rr_wen_k%0d got=%0b exp=%0b", k, b_wen, k % 2); end
            if (b_wen && id_q.size() != 0) begin
                eid = id_q.pop_front();
                n_cmp++; if (b_gid !== eid) begin n_fail++; $display("FAIL rr_gid got=%0d exp=%0d", b_gid, eid); end
                n_cmp++; if (b_din !== 8'h10 + 8'(eid)) begin n_fail++; $display("FAIL rr_data got=%02h exp=%02h", b_din, 8'h10 + 8'(eid)); end
            end
        end
        @(posedge clk); #1;
        b_valid = '0;
        n_cmp++; if (id_q.size() != 0) begin n_fail++; $display("FAIL rr_left got=%0d exp=0", id_q.size()); end
        n_cmp++; if (b_wc !== 16'd6) begin n_fail++; $display("FAIL rr_wc got=%0d exp=6", b_wc); end
    endtask

    task automatic test_full_stall();
        int sent = 0;
        int stall = 0;
        bit done = 1'b0;
        bit chk_resume = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h50 + 8'(i));
        a_valid = 4'b0010;
        a_data[15:8] = 8'h50;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            bit acc;
            logic [7:0] e;
            acc = 1'b0;
            @(negedge clk);
            if (a_full) begin
                n_cmp++; if (a_wen !== 1'b0) begin n_fail++; $display("FAIL stall_wen got=%0b exp=0", a_wen); end
                n_cmp++; if (a_ready[1] !== 1'b0) begin n_fail++; $display("FAIL stall_ready got=%0b exp=0", a_ready[1]); end
                n_cmp++; if (a_gv !== 1'b1 || a_gid !== 2'd1) begin n_fail++; $display("FAIL stall_lock got=%0b/%0d exp=1/1", a_gv, a_gid); end
                n_cmp++; if (dA.beat_cnt_q !== 8'd2) begin n_fail++; $display("FAIL stall_beat_cnt got=%0d exp=2", dA.beat_cnt_q); end
            end
            if (chk_resume) begin
                chk_resume = 1'b0;
                n_cmp++; if (a_wen !== 1'b1) begin n_fail++; $display("FAIL stall_resume got=%0b exp=1", a_wen); end
            end
            if (a_wen) begin
                acc = 1'b1;
                n_cmp++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL stall_extra_write got=%02h exp=none", a_din); end
                else begin
                    e = exp_q.pop_front();
                    if (a_din !== e) begin n_fail++; $display("FAIL stall_data got=%02h exp=%02h", a_din, e); end
                end
            end
            @(posedge clk); #1;
            if (acc) sent++;
            if (sent == 4) begin
                a_valid = '0; a_full = 1'b0; done = 1'b1;
            end else begin
                a_data[15:8] = 8'h50 + 8'(sent);
                if (sent == 2 && stall < 5) begin
                    a_full = 1'b1; stall++;
                end else begin
                    if (a_full) chk_resume = 1'b1;
                    a_full = 1'b0;
                end
            end
        end
        n_cmp++; if (!done) begin n_fail++; $display("FAIL stall_timeout got=%0d exp=4 beats", sent); end
        n_cmp++; if (stall != 5) begin n_fail++; $display("FAIL stall_cycles got=%0d exp=5", stall); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_left got=%0d exp=0", exp_q.size()); end
        n_cmp++; if (a_wc !== 16'd10) begin n_fail++; $display("FAIL stall_wc got=%0d exp=10", a_wc); end
    endtask

    task automatic test_early_drop();
        int sent3 = 0;
        int nw = 0;
        int gaps = 0;
        bit done = 1'b0;
        exp_q.delete(); id_q.delete();
        exp_q.push_back(8'h30); exp_q.push_back(8'h31); exp_q.push_back(8'hC0);
        id_q.push_back(2'd3);   id_q.push_back(2'd3);   id_q.push_back(2'd0);
        a_data[31:24] = 8'h30;
        a_data[7:0]   = 8'hC0;
        a_valid = 4'b1001;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            bit acc;
            logic [1:0] gs;
            logic [7:0] e;
            logic [1:0] ei;
            acc = 1'b0; gs = '0;
            @(negedge clk);
            if (nw == 2 && !a_gv) gaps++;
            if (a_wen) begin
                acc = 1'b1; gs = a_gid; nw++;
                n_cmp++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL drop_extra_write got=%02h exp=none", a_din); end
                else begin
                    e = exp_q.pop_front(); ei = id_q.pop_front();
                    if (a_din !== e || a_gid !== ei) begin
                        n_fail++; $display("FAIL drop_beat got=%02h/id%0d exp=%02h/id%0d", a_din, a_gid, e, ei);
                    end
                end
            end
            @(posedge clk); #1;
            if (acc) begin
                if (gs == 2'd3) begin
                    sent3++;
                    if (sent3 == 2) a_valid[3] = 1'b0;
                    else a_data[31:24] = 8'h31;
                end else if (gs == 2'd0) begin
                    a_valid[0] = 1'b0; done = 1'b1;
                end
            end
        end
        a_valid = '0;
        n_cmp++; if (!done) begin n_fail++; $display("FAIL drop_timeout got=%0d exp=3 beats", nw); end
        n_cmp++; if (gaps != 1) begin n_fail++; $display("FAIL drop_idle_cycles got=%0d exp=1", gaps); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drop_left got=%0d exp=0", exp_q.size()); end
        n_cmp++; if (a_wc !== 16'd13) begin n_fail++; $display("FAIL drop_wc got=%0d exp=13", a_wc); end
    endtask

    task automatic test_reset_mid_burst();
        bit seen = 1'b0;
        a_data[7:0] = 8'hE0;
        a_valid = 4'b0001;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            if (a_wen) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL rstmid_first_beat got=none exp=write"); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (a_wen !== 1'b1) begin n_fail++; $display("FAIL rstmid_beat1 got=%0b exp=1", a_wen); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (a_gv !== 1'b0) begin n_fail++; $display("FAIL rstmid_gv got=%0b exp=0", a_gv); end
        n_cmp++; if (a_wen !== 1'b0) begin n_fail++; $display("FAIL rstmid_wen got=%0b exp=0", a_wen); end
        n_cmp++; if (a_ready !== 4'b0) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=0000", a_ready); end
        n_cmp++; if (a_din !== 8'h00) begin n_fail++; $display("FAIL rstmid_din got=%02h exp=00", a_din); end
        n_cmp++; if (a_wc !== 16'd0) begin n_fail++; $display("FAIL rstmid_wc got=%0d exp=0", a_wc); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_gv !== 1'b1 || a_gid !== 2'd0) begin n_fail++; $display("FAIL rstmid_regrant got=%0b/%0d exp=1/0", a_gv, a_gid); end
        n_cmp++; if (a_wen !== 1'b1 || a_din !== 8'hE0) begin n_fail++; $display("FAIL rstmid_retry got=%0b/%02h exp=1/e0", a_wen, a_din); end
        n_cmp++; if (a_wc !== 16'd0) begin n_fail++; $display("FAIL rstmid_wc_after got=%0d exp=0", a_wc); end
        @(posedge clk); #1;
        a_valid = '0;
        n_cmp++; if (a_wc !== 16'd1) begin n_fail++; $display("FAIL rstmid_wc_one got=%0d exp=1", a_wc); end
    endtask

    task automatic test_wrap();
        int beats = 0;
        bit done = 1'b0;
        exp_q.delete();
        c_data[7:0] = 8'h00;
        exp_q.push_back(8'h00);
        c_valid = 4'b0001;
        for (int cyc = 0; cyc < 70000 && !done; cyc++) begin
            bit acc;
            logic [7:0] e;
            acc = 1'b0;
            @(negedge clk);
            if (c_wen) begin
                acc = 1'b1;
                n_cmp++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL wrap_extra_write got=%02h exp=none", c_din); end
                else begin
                    e = exp_q.pop_front();
                    if (c_din !== e) begin n_fail++; $display("FAIL wrap_data got=%02h exp=%02h", c_din, e); end
                end
            end
            @(posedge clk); #1;
            if (acc) begin
                beats++;
                if (beats == 65537) begin c_valid = '0; done = 1'b1; end
                else begin c_data[7:0] = 8'(beats); exp_q.push_back(8'(beats)); end
            end
        end
        c_valid = '0;
        n_cmp++; if (!done) begin n_fail++; $display("FAIL wrap_timeout got=%0d exp=65537 beats", beats); end
        n_cmp++; if (c_wc !== 16'd1) begin n_fail++; $display("FAIL wrap_wc got=%0d exp=1", c_wc); end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_round_robin();
        test_full_stall();
        test_early_drop();
        test_reset_mid_burst();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write arbiter that lets `NUM_REQ` producers share the single write port of the team's synchronous FIFO. Each producer presents data with a valid/ready handshake. The arbiter locks the port to one producer for a burst of up to `BURST_MAX` beats, then re-arbitrates. It drives the FIFO's write enable and write data directly and honours the FIFO's `full` flag. It sits between the producer agents and the FIFO write side, in the same clock domain.

## Interface
- `NUM_REQ`, 4: number of producers; must be 2..16.
- `DATA_WIDTH`, 8: data width; must match the FIFO.
- `BURST_MAX`, 4: maximum beats per grant; must be 1..255.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  NUM_REQ  per-producer valid; bit i belongs to producer i.
- `req_data`  in  NUM_REQ*DATA_WIDTH  per-producer data; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  per-producer ready; combinational.
- `fifo_full`  in  1  FIFO `full` flag.
- `fifo_w_en`  out  1  FIFO write enable; combinational.
- `fifo_data_in`  out  DATA_WIDTH  FIFO write data; combinational.
- `grant_valid`  out  1  registered; high while in the BURST state.
- `grant_id`  out  $clog2(NUM_REQ)  registered; index of the current owner.
- `write_count`  out  16  registered; total accepted beats, wraps modulo 2^16.

## Operation
- FSM has two states, IDLE and BURST. The reset state is IDLE.
- **IDLE:**
  - If any `req_valid` bit is high, select a winner by round-robin.
  - The search starts at `last_id + 1` (modulo `NUM_REQ`) and takes the first set bit.
  - Next state is BURST. Load `grant_id` with the winner, load `last_id` with the winner, and clear `beat_cnt` to 0.
  - If no `req_valid` bit is high, stay in IDLE.
- **BURST, owner o:**
  - `req_ready[o]` = !`fifo_full`. All other `req_ready` bits are 0.
  - A beat is accepted when `req_valid[o]` && `req_ready[o]`.
  - While a beat is accepted: `fifo_w_en` = 1 and `fifo_data_in` = slice o of `req_data`.
  - While no beat is accepted: `fifo_w_en` = 0 and `fifo_data_in` = 0.
  - On each accepted beat, `beat_cnt` and `write_count` increment.
  - Return to IDLE when either:
    - a beat is accepted with `beat_cnt` == `BURST_MAX`-1, or
    - `req_valid[o]` is 0 in any BURST cycle, regardless of `fifo_full`.
  - Stay in BURST when `fifo_full` is high and `req_valid[o]` is high. `beat_cnt` is held and the lock is kept.
- In IDLE, all `req_ready` bits are 0 and `fifo_w_en` is 0.
- Producers must hold `req_valid` and data stable until accepted. The arbiter does not check this.
- `beat_cnt` is 8 bits wide. `last_id` has the same width as `grant_id`.
- **Reset values** (applied immediately on `rst` assertion, no clock edge needed):
  - state = IDLE.
  - `grant_valid` = 0, `grant_id` = 0, `write_count` = 0, `beat_cnt` = 0.
  - `last_id` = `NUM_REQ`-1, so producer 0 wins first.
  - Combinational outputs resolve to 0 while reset is held.
- **Reset mid-burst:** no beat is written in the reset cycle. Any beat in progress is lost, and the producer retries after reset.

## Timing
- Arbitration latency: `req_valid` first seen in IDLE at edge N gives `req_ready` high in the cycle after edge N (one-cycle grant latency).
- Re-arbitration bubble: every BURST→IDLE exit costs exactly one idle cycle before the next grant.
- Sustained throughput: `BURST_MAX`/(`BURST_MAX`+1) beats per cycle with all producers active and the FIFO never full.
- `fifo_full` to `req_ready` to `fifo_w_en` is a same-cycle combinational path. No write is ever issued while `fifo_full` = 1.
- `grant_valid` and `grant_id` change on the same edge as the state transition.
- `write_count` reflects beats up to and including the previous edge.
- Round-robin wrap: after owner `NUM_REQ`-1, the search starts at 0.

## Test plan
- **Single producer, long stream.** `NUM_REQ`=4, `BURST_MAX`=4, producer 2 streams 6 beats 0xA0..0xA5 with the FIFO never full.
  - Required: 4 writes 0xA0..0xA3, then one bubble cycle, then 0xA4 and 0xA5.
  - `grant_id` = 2 throughout. `write_count` = 6.
- **All producers valid.** All 4 producers valid continuously with 1-beat bursts (`BURST_MAX`=1).
  - Required grant order after reset: 0,1,2,3,0,1.
  - `fifo_w_en` high every other cycle.
- **Full stall.** `fifo_full` forced high for 5 cycles during producer 1's beat 2.
  - Required: `fifo_w_en` = 0 and `req_ready[1]` = 0 for those 5 cycles.
  - The lock is held with `beat_cnt` = 2.
  - Beats resume on the first cycle `fifo_full` = 0. No data is lost or duplicated.
- **Early valid drop.** Producer 3 drops `req_valid` after 2 of 4 beats while producer 0 is waiting.
  - Required: BURST→IDLE, then the next grant goes to producer 0.
- **Reset mid-burst.** `rst` asserted asynchronously between edges during beat 1 of producer 0.
  - Required: `grant_valid`, `fifo_w_en` and `req_ready` go to 0 immediately.
  - After release, producer 0 wins first with `write_count` = 0.
- **Write counter wrap.** 65537 accepted beats.
  - Required: `write_count` = 1.
